tx_manch_serializer: RTL and testbench

//  Serializer directly downstream of the TX polarity-comma inserter. Accepts 10b

---
 rtl/tx_phy_pkg.sv | 25 ++
 rtl/tx_chip_timer.sv | 47 ++++
 rtl/tx_manch_serializer.sv | 141 ++++++++++++++
 tb/tb_tx_manch_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_phy_pkg.sv
// Shared TX PHY definitions: K-code symbols (bit0 is transmitted first),
// serializer FSM encoding and the per-chip line coding helper.
package tx_phy_pkg;

  localparam logic [9:0] K28_5_P = 10'b01_0111_1100;
  localparam logic [9:0] K28_2_P = 10'b10_1011_1100;
  localparam logic [9:0] K28_6_N = 10'b10_0100_0011;

  localparam int SYM_BITS = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  // Manchester sends ~b then b (bit 1 -> 0,1); NRZ repeats the bit on both chips.
  function automatic logic chip_code(input logic b, input logic half, input logic manch);
    if (manch) begin
      return half ? b : ~b;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/tx_chip_timer.sv
// Chip/half/bit counters for one 20-chip symbol; held at zero while disabled.
// chip_end marks the last clk of a chip, sym_end the last clk of chip 19.
module tx_chip_timer
  import tx_phy_pkg::*;
#(
  parameter int CLK_PER_CHIP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic chip_end,
  output logic sym_end,
  output logic half
);

  localparam int CW = (CLK_PER_CHIP > 1) ? $clog2(CLK_PER_CHIP) : 1;

  logic [CW-1:0] chip_cnt;
  logic [3:0]    bit_cnt;

  assign chip_end = en && (chip_cnt == CW'(CLK_PER_CHIP - 1));
  assign sym_end  = chip_end && half && (bit_cnt == 4'(SYM_BITS - 1));

  // Advance chip, half and bit position; restart from zero whenever disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chip_cnt <= {CW{1'b0}};
      half     <= 1'b0;
      bit_cnt  <= 4'd0;
    end else if (!en) begin
      chip_cnt <= {CW{1'b0}};
      half     <= 1'b0;
      bit_cnt  <= 4'd0;
    end else if (chip_end) begin
      chip_cnt <= {CW{1'b0}};
      half     <= ~half;
      if (half) begin
        bit_cnt <= (bit_cnt == 4'(SYM_BITS - 1)) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        bit_cnt <= bit_cnt;
      end
    end else begin
      chip_cnt <= chip_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tx_manch_serializer.sv
// 10b symbol serializer, LSB first, Manchester or NRZ chosen per symbol.
// Holding + shift register give gap-free streaming; underruns fill with IDLE_SYM.
module tx_manch_serializer
  import tx_phy_pkg::*;
#(
  parameter int         CLK_PER_CHIP = 4,
  parameter logic [9:0] IDLE_SYM     = K28_2_P,
  parameter bit         IDLE_FILL    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [9:0] i_sym,
  input  logic       i_vld,
  output logic       o_rdy,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_sym_start,
  output logic       o_underrun
);

  tx_state_e  state;
  logic [9:0] shift;
  logic [9:0] hold;
  logic       rdy;
  logic       mode;
  logic       txd;
  logic       sym_start;
  logic       underrun;

  logic       chip_end;
  logic       sym_end;
  logic       half;

  logic       accept;
  logic       load;
  logic [9:0] load_sym;
  logic       fill;
  logic       stop;
  logic       hold_load;
  logic       hold_drain;

  tx_chip_timer #(
    .CLK_PER_CHIP(CLK_PER_CHIP)
  ) u_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .en      (state == ST_RUN),
    .chip_end(chip_end),
    .sym_end (sym_end),
    .half    (half)
  );

  // Decide what enters the shift register and what happens to the holding register.
  always_comb begin
    accept     = i_vld & rdy;
    load       = 1'b0;
    load_sym   = i_sym;
    fill       = 1'b0;
    stop       = 1'b0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    case (state)
      ST_IDLE: begin
        load = accept;
      end
      ST_RUN: begin
        if (sym_end) begin
          if (!rdy) begin
            load       = 1'b1;
            load_sym   = hold;
            hold_drain = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else if (IDLE_FILL) begin
            load     = 1'b1;
            load_sym = IDLE_SYM;
            fill     = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end else begin
          hold_load = accept;
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // FSM, shift/holding registers and the registered line chip.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      shift     <= 10'd0;
      hold      <= 10'd0;
      rdy       <= 1'b1;
      mode      <= 1'b0;
      txd       <= 1'b0;
      sym_start <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sym_start <= load;
      underrun  <= fill;
      // The output register always holds the chip of the cycle that follows.
      if (load) begin
        state <= ST_RUN;
        shift <= load_sym;
        mode  <= i_en;
        txd   <= chip_code(load_sym[0], 1'b0, i_en);
      end else if (stop) begin
        state <= ST_IDLE;
        txd   <= 1'b0;
      end else if (chip_end && half) begin
        shift <= {1'b0, shift[9:1]};
        txd   <= chip_code(shift[1], 1'b0, mode);
      end else if (chip_end) begin
        txd <= chip_code(shift[0], 1'b1, mode);
      end else begin
        txd <= txd;
      end

      if (hold_load) begin
        hold <= i_sym;
        rdy  <= 1'b0;
      end else if (hold_drain) begin
        rdy <= 1'b1;
      end else begin
        rdy <= rdy;
      end
    end
  end

  assign o_rdy       = rdy;
  assign o_txd       = txd;
  assign o_busy      = (state == ST_RUN);
  assign o_sym_start = sym_start;
  assign o_underrun  = underrun;

endmodule

// File: tb/tb_tx_manch_serializer.sv
// Scoreboard bench: three serializer lanes with different chip rates and fill modes,
// each with a driver pushing accepted symbols and a monitor decoding the line.
module tb_tx_manch_serializer;

  localparam logic [9:0] IDLE  = 10'h2BC;
  localparam int         NLANE = 3;

  logic clk = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input int ln, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0h, expected %0h at %0t", ln, name, act, exp, $time);
    end
  endtask

  // Line level of cycle cyc within a symbol, straight from the line-code rules.
  function automatic logic line_chip(input logic [9:0] s, input bit manch, input int cyc, input int cpc);
    int         chip;
    logic       b;
    logic [1:0] pat;
    chip = cyc / cpc;
    b    = s[chip / 2];
    if (!manch) return b;
    pat = b ? 2'b10 : 2'b01;
    return pat[chip % 2];
  endfunction

  for (genvar g = 0; g < NLANE; g++) begin : lane
    localparam int C   = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    localparam bit F   = (g != 0);
    localparam int SYM = 20 * C;

    logic       rst, en, vld, rdy, txd, busy, ss, ur;
    logic [9:0] sym;
    logic [9:0] exp_q[$];
    bit         done = 1'b0;

    bit         active = 1'b0;
    int         k = 0;
    int         errs = 0;
    logic [9:0] cs = 10'd0;
    bit         cm = 1'b0;
    bit         exp_ur;

    tx_manch_serializer #(
      .CLK_PER_CHIP(C),
      .IDLE_SYM    (IDLE),
      .IDLE_FILL   (F)
    ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_sym      (sym),
      .i_vld      (vld),
      .o_rdy      (rdy),
      .o_txd      (txd),
      .o_busy     (busy),
      .o_sym_start(ss),
      .o_underrun (ur)
    );

    task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [9:0] s, input bit jitter);
      int t = 0;
      sym = s;
      vld = 1'b1;
      while (!rdy && t < 4 * SYM) begin
        @(negedge clk);
        t++;
        if (jitter && $urandom_range(0, 7) == 0) en = ~en;
      end
      check(g, "send_timeout", t < 4 * SYM, 1);
      exp_q.push_back(s);
      @(negedge clk);
      vld = 1'b0;
      sym = 10'($urandom);
    endtask

    task automatic wait_start();
      int t = 0;
      while (!ss && t < 4 * SYM) begin
        @(negedge clk);
        t++;
      end
      check(g, "start_timeout", t < 4 * SYM, 1);
    endtask

    initial begin : drv
      rst = 1'b1; en = 1'b0; vld = 1'b0; sym = 10'd0;
      tick(3);
      check(g, "reset_values", {txd, rdy, busy, ss, ur}, 5'b01000);
      rst = 1'b0;
      tick(2);
      // single Manchester symbol, then silence
      en = 1'b1;
      send(10'h17C, 1'b0);
      tick(2 * SYM + 4);
      // NRZ all-ones then all-zeros back to back
      en = 1'b0;
      send(10'h3FF, 1'b0);
      send(10'h000, 1'b0);
      tick(2 * SYM + 4);
      // random stream with mid-symbol mode toggles
      for (int i = 0; i < 16; i++) begin
        en = 1'($urandom);
        send(10'($urandom), 1'b1);
      end
      tick(3 * SYM);
      // mode change inside a symbol, then a bypass offered on the boundary cycle
      en = 1'b0;
      send(10'h155, 1'b0);
      send(10'h0F0, 1'b0);
      wait_start();
      tick(SYM / 2);
      en = 1'b1;
      tick(SYM / 2 - 1);
      check(g, "bypass_rdy", rdy, 1);
      sym = 10'h2A7;
      vld = 1'b1;
      exp_q.push_back(10'h2A7);
      tick(1);
      vld = 1'b0;
      sym = 10'($urandom);
      // starve the serializer, then resume
      tick(4 * SYM);
      send(10'h0C3, 1'b0);
      tick(2 * SYM + 4);
      // reset in the middle of chip 7
      send(10'h1E1, 1'b0);
      wait_start();
      tick(7 * C);
      rst = 1'b1;
      #1;
      check(g, "midsym_reset", {txd, rdy, busy, ss, ur}, 5'b01000);
      exp_q.delete();
      tick(3);
      rst = 1'b0;
      tick(2);
      en = 1'b0;
      send(10'h30F, 1'b0);
      tick(2 * SYM + 4);
      done = 1'b1;
    end

    initial begin : mon
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          active = 1'b0;
          k = 0;
        end else begin
          if (ss) begin
            if (active) check(g, "sym_period", k, SYM);
            exp_ur = (exp_q.size() == 0);
            check(g, "underrun_flag", ur, exp_ur);
            cs     = exp_ur ? IDLE : exp_q.pop_front();
            cm     = en;
            active = 1'b1;
            k      = 0;
            errs   = 0;
          end else begin
            check(g, "underrun_quiet", ur, 0);
            if (active && k == SYM) begin
              check(g, "next_start", ss, (exp_q.size() != 0) || F);
              active = 1'b0;
            end
          end
          if (active) begin
            if (txd !== line_chip(cs, cm, k, C) || busy !== 1'b1) errs++;
            if (k == SYM - 1) check(g, "sym_wave", errs, 0);
            k++;
          end else begin
            check(g, "idle_line", {busy, txd}, 2'b00);
          end
        end
      end
    end
  end

  initial begin : fin
    int c = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && c < 50000) begin
      @(posedge clk);
      c++;
    end
    check(-1, "run_timeout", c < 50000, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
